// File: rtl/calc_sequencer.sv
// calc_sequencer: runs a stored program on the calculator command port and reports one result register
module calc_sequencer #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        prog_we,
    input  logic [2:0]  prog_addr,
    input  logic [10:0] prog_data,
    input  logic [3:0]  prog_len,
    input  logic [1:0]  res_addr,
    input  logic        start,
    output logic [1:0]  calc_rd_addr,
    output logic [3:0]  calc_immediate,
    output logic [1:0]  calc_we_addr,
    output logic [2:0]  calc_control,
    input  logic [3:0]  calc_rd_data,
    output logic        busy,
    output logic        done,
    output logic [3:0]  result
);
    localparam logic [10:0] NOP = {3'b001, 2'b00, 2'b00, 4'b0000};

    typedef enum logic [1:0] {IDLE, RUN, READ} state_t;

    state_t      state;
    logic [10:0] mem [DEPTH];
    logic [10:0] cmd;
    logic [2:0]  pc;
    logic [3:0]  len;
    logic [1:0]  res;
    logic [3:0]  len_in;
    logic [10:0] first;
    logic        accept;

    assign {calc_control, calc_we_addr, calc_rd_addr, calc_immediate} = cmd;
    assign len_in = (prog_len > 4'd8) ? 4'd8 : prog_len;
    // a write to slot 0 in the launching cycle must be seen by the first instruction
    assign first  = (state == IDLE && prog_we && prog_addr == 3'd0) ? prog_data : mem[0];
    // READ is the last busy cycle, so a start there launches back-to-back with done
    assign accept = start && (state == IDLE || state == READ);

    // sequencer FSM: program store, instruction issue and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cmd    <= NOP;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= 4'd0;
            pc     <= 3'd0;
            len    <= 4'd0;
            res    <= 2'd0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= NOP;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (prog_we) mem[prog_addr] <= prog_data;
                RUN: begin
                    if ({1'b0, pc} == len - 4'd1) begin
                        cmd   <= {3'b001, res, res, 4'b0000};
                        state <= READ;
                    end else begin
                        pc  <= pc + 3'd1;
                        cmd <= mem[pc + 3'd1];
                    end
                end
                READ: begin
                    result <= calc_rd_data;
                    done   <= 1'b1;
                    cmd    <= NOP;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (accept) begin
                len  <= len_in;
                res  <= res_addr;
                pc   <= 3'd0;
                busy <= 1'b1;
                if (len_in != 4'd0) begin
                    cmd   <= first;
                    state <= RUN;
                end else begin
                    cmd   <= {3'b001, res_addr, res_addr, 4'b0000};
                    state <= READ;
                end
            end
        end
    end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: scoreboard bench for calc_sequencer with a behavioural calculator attached
module tb_calc_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        prog_we = 1'b0;
    logic [2:0]  prog_addr = 3'd0;
    logic [10:0] prog_data = 11'd0;
    logic [3:0]  prog_len = 4'd0;
    logic [1:0]  res_addr = 2'd0;
    logic        start = 1'b0;
    logic [1:0]  calc_rd_addr;
    logic [3:0]  calc_immediate;
    logic [1:0]  calc_we_addr;
    logic [2:0]  calc_control;
    logic [3:0]  calc_rd_data;
    logic        busy;
    logic        done;
    logic [3:0]  result;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_done = 0;

    typedef struct {
        int         c;
        logic [3:0] v;
    } exp_t;
    exp_t sb[$];

    logic [3:0] regs [4];
    logic       ld = 1'b0;
    logic [3:0] ld_val [4];

    calc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .res_addr(res_addr), .start(start),
        .calc_rd_addr(calc_rd_addr), .calc_immediate(calc_immediate),
        .calc_we_addr(calc_we_addr), .calc_control(calc_control),
        .calc_rd_data(calc_rd_data), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // free-running cycle count used to time done against start
    always @(posedge clk) cyc <= cyc + 1;

    // calculator model: combinational read, ALU write on every negedge, no reset
    assign calc_rd_data = regs[calc_rd_addr];
    always @(negedge clk) begin
        if (ld) begin
            for (int i = 0; i < 4; i++) regs[i] <= ld_val[i];
        end else begin
            case (calc_control)
                3'b000:  regs[calc_we_addr] <= regs[calc_rd_addr] & calc_immediate;
                3'b001:  regs[calc_we_addr] <= regs[calc_rd_addr] | calc_immediate;
                3'b010:  regs[calc_we_addr] <= regs[calc_rd_addr] + calc_immediate;
                3'b100:  regs[calc_we_addr] <= regs[calc_rd_addr] ^ calc_immediate;
                3'b110:  regs[calc_we_addr] <= regs[calc_rd_addr] - calc_immediate;
                default: regs[calc_we_addr] <= regs[calc_rd_addr];
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // scoreboard consumer: every done pulse must match the oldest queued run
    always @(posedge clk) begin
        #1;
        if (done) begin
            n_done++;
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", {28'd0, result}, {28'd0, e.v});
                check("done_cycle", cyc, e.c);
            end
        end
    end

    task automatic setregs(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        @(posedge clk); #1;
        ld_val[0] = a; ld_val[1] = b; ld_val[2] = c; ld_val[3] = d;
        ld = 1'b1;
        @(posedge clk); #1;
        ld = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [10:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic check_nop(input string tag);
        check({tag, "_ctl"}, {29'd0, calc_control}, 32'd1);
        check({tag, "_rd"}, {30'd0, calc_rd_addr}, 32'd0);
        check({tag, "_we"}, {30'd0, calc_we_addr}, 32'd0);
        check({tag, "_imm"}, {28'd0, calc_immediate}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    // start a run, queue its expected result, track busy, optionally poke start/prog_we mid-run
    task automatic run(input logic [3:0] plen, input logic [1:0] ra, input logic [3:0] ev, input int poke);
        int n;
        int d0;
        exp_t e;
        n = (plen > 4'd8) ? 8 : int'(plen);
        d0 = n_done;
        @(negedge clk);
        prog_len = plen; res_addr = ra; start = 1'b1;
        @(posedge clk); #1;
        e.c = cyc + n + 1;
        e.v = ev;
        sb.push_back(e);
        start = 1'b0;
        check("busy_start", {31'd0, busy}, 32'd1);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            start = (k == poke);
            prog_we = (k == poke);
            prog_addr = 3'd0;
            prog_data = {3'b010, 2'b00, 2'b00, 4'b0001};
            @(posedge clk); #1;
            start = 1'b0;
            prog_we = 1'b0;
            check("busy_run", {31'd0, busy}, 32'd1);
        end
        @(posedge clk); #2;
        check("busy_end", {31'd0, busy}, 32'd0);
        check("sb_drained", sb.size(), 32'd0);
        check("one_done", n_done - d0, 32'd1);
        sb.delete();
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 4; i++) ld_val[i] = 4'd0;
        ld = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_nop("reset");
        check("reset_result", {28'd0, result}, 32'd0);
        ld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        setregs(4'd3, 4'd5, 4'd9, 4'd12);
        repeat (10) @(posedge clk);
        #1;
        check("idle_r0", {28'd0, regs[0]}, 32'd3);
        check("idle_r1", {28'd0, regs[1]}, 32'd5);
        check("idle_r2", {28'd0, regs[2]}, 32'd9);
        check("idle_r3", {28'd0, regs[3]}, 32'd12);

        setregs(4'd0, 4'd0, 4'd0, 4'd0);
        wr(3'd0, {3'b010, 2'b01, 2'b00, 4'b0101});
        wr(3'd1, {3'b010, 2'b10, 2'b01, 4'b0011});
        wr(3'd2, {3'b110, 2'b10, 2'b10, 4'b0001});
        run(4'd3, 2'd2, 4'd7, 0);

        setregs(4'd0, 4'd0, 4'd0, 4'd0);
        wr(3'd0, {3'b010, 2'b11, 2'b00, 4'b1111});
        wr(3'd1, {3'b010, 2'b11, 2'b11, 4'b0010});
        run(4'd2, 2'd3, 4'd1, 0);

        wr(3'd0, {3'b010, 2'b00, 2'b00, 4'b0010});
        for (int i = 1; i < 8; i++) wr(3'(i), {3'b010, 2'b00, 2'b00, 4'b0001});
        setregs(4'd0, 4'd0, 4'd0, 4'd0);
        run(4'd8, 2'd0, 4'd9, 2);
        setregs(4'd0, 4'd0, 4'd0, 4'd0);
        run(4'd1, 2'd0, 4'd2, 0);

        setregs(4'd2, 4'd6, 4'd4, 4'd8);
        run(4'd0, 2'd1, 4'd6, 0);

        setregs(4'd0, 4'd0, 4'd0, 4'd0);
        run(4'd12, 2'd0, 4'd9, 0);

        setregs(4'd0, 4'd0, 4'd0, 4'd0);
        d0 = n_done;
        @(negedge clk);
        prog_len = 4'd8; res_addr = 2'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrun_ctl_before", {29'd0, calc_control}, 32'd2);
        rst_n = 1'b0;
        #1;
        check_nop("midrun_reset");
        repeat (4) @(posedge clk);
        #1;
        check("midrun_no_done", n_done - d0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        setregs(4'd0, 4'd0, 4'd0, 4'd0);
        run(4'd1, 2'd0, 4'd0, 0);
        setregs(4'd0, 4'd0, 4'd0, 4'd0);
        wr(3'd0, {3'b010, 2'b01, 2'b00, 4'b0101});
        wr(3'd1, {3'b010, 2'b10, 2'b01, 4'b0011});
        wr(3'd2, {3'b110, 2'b10, 2'b10, 4'b0001});
        run(4'd3, 2'd2, 4'd7, 0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
